auto_level_ctrl: RTL and testbench

//  Per-frame statistics and configuration controller for the auto-level datapath.
//  - Watches one frame of RGB pixels and tracks the frame minimum and maximum over all three channels.
//  - At end of frame, divides sequentially to compute the stretch scale.
//  - Publishes low_th, high_th and scale as a coherent set for the auto-level stage to apply on the next frame.
//  - Sits beside the pixel stream, ahead of the auto-level stage.

---
 rtl/auto_level_ctrl.sv | 101 ++++++++++
 tb/tb_auto_level_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/auto_level_ctrl.sv
// auto_level_ctrl: per-frame min/max statistics and sequential gain divider for auto-level
module auto_level_ctrl #(
    parameter int WIDTH     = 32,
    parameter int SCALE_BIT = 8,
    parameter int MIN_RANGE = 16 << SCALE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             sof,
    input  logic             eof,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] low_th,
    output logic [WIDTH-1:0] high_th,
    output logic [WIDTH-1:0] scale,
    output logic             cfg_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DIVIDEND   = WIDTH'(1) << (8 + 2 * SCALE_BIT);
    localparam logic [WIDTH-1:0] IDENT_HIGH = WIDTH'(255) << SCALE_BIT;
    localparam logic [WIDTH-1:0] UNITY      = WIDTH'(1) << SCALE_BIT;

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, PUBLISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] mn, mx, rem, quo, pmin, pmax, nmin, nmax, rng, dv;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    cnt;
    logic             take, ge;

    assign pix_ready = (state == IDLE) || (state == ACCUM);
    assign busy      = !pix_ready;

    // Beat statistics folding and one restoring-division step
    always_comb begin
        take  = pix_valid && pix_ready && (sof || state == ACCUM);
        pmin  = (R < G) ? ((R < B) ? R : B) : ((G < B) ? G : B);
        pmax  = (R > G) ? ((R > B) ? R : B) : ((G > B) ? G : B);
        nmin  = (sof || pmin < mn) ? pmin : mn;
        nmax  = (sof || pmax > mx) ? pmax : mx;
        rng   = nmax - nmin;
        dv    = mx - mn;
        trial = {rem, quo[WIDTH-1]};
        ge    = trial >= {1'b0, dv};
    end

    // Frame FSM: accumulate, divide MSB-first with the dividend shifted out of quo, publish atomically
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            low_th    <= '0;
            high_th   <= IDENT_HIGH;
            scale     <= UNITY;
            cfg_valid <= 1'b0;
            mn        <= '0;
            mx        <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else begin
            cfg_valid <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        mn    <= nmin;
                        mx    <= nmax;
                        state <= ACCUM;
                        if (eof && rng < WIDTH'(MIN_RANGE)) begin
                            mn    <= '0;
                            mx    <= IDENT_HIGH;
                            quo   <= UNITY;
                            state <= PUBLISH;
                        end else if (eof) begin
                            quo   <= DIVIDEND;
                            rem   <= '0;
                            cnt   <= '0;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= ge ? WIDTH'(trial - {1'b0, dv}) : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH - 1)) ? PUBLISH : DIVIDE;
                end
                default: begin
                    low_th    <= mn;
                    high_th   <= mx;
                    scale     <= quo;
                    cfg_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_auto_level_ctrl.sv
// tb_auto_level_ctrl: scoreboard bench for the auto-level statistics controller
module tb_auto_level_ctrl;
    localparam int W  = 32;
    localparam int SB = 8;

    logic         clk = 0, reset = 1, pix_valid = 0, sof = 0, eof = 0;
    logic [W-1:0] R = 0, G = 0, B = 0;
    logic         pix_ready, cfg_valid, busy;
    logic [W-1:0] low_th, high_th, scale;

    auto_level_ctrl #(.WIDTH(W), .SCALE_BIT(SB)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sof(sof), .eof(eof), .R(R), .G(G), .B(B),
        .low_th(low_th), .high_th(high_th), .scale(scale),
        .cfg_valid(cfg_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo, hi, sc;
        int           at;
    } exp_t;

    exp_t         q[$];
    exp_t         x;
    int           checks = 0, fails = 0, n_cfg = 0;
    logic         m_act = 0;
    logic [W-1:0] m_mn, m_mx;

    // Scoreboard: every published set is popped and compared, including its arrival cycle
    always @(negedge clk) begin
        if (!reset && cfg_valid) begin
            n_cfg++;
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL spurious_cfg cyc=%0d got cfg_valid=1 expected 0", cyc);
            end else begin
                x = q.pop_front();
                checks += 4;
                if (low_th  !== x.lo) begin fails++; $display("FAIL low_th got %0d expected %0d", low_th, x.lo); end
                if (high_th !== x.hi) begin fails++; $display("FAIL high_th got %0d expected %0d", high_th, x.hi); end
                if (scale   !== x.sc) begin fails++; $display("FAIL scale got %0d expected %0d", scale, x.sc); end
                if (cyc     !== x.at) begin fails++; $display("FAIL cfg_cycle got %0d expected %0d", cyc, x.at); end
            end
        end
    end

    // Present one beat, wait for acceptance, update the reference model
    task automatic beat(input logic [W-1:0] r, g, b, input logic s, e);
        logic [W-1:0] pmn, pmx, rng;
        int n = 0;
        R = r; G = g; B = b; sof = s; eof = e; pix_valid = 1;
        while (!pix_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!pix_ready) begin
            fails++;
            $display("FAIL beat_accept got pix_ready=0 expected 1 within 100 cycles");
        end
        pmn = (r < g) ? r : g; pmn = (b < pmn) ? b : pmn;
        pmx = (r > g) ? r : g; pmx = (b > pmx) ? b : pmx;
        if (s) begin
            m_mn = pmn; m_mx = pmx; m_act = 1;
        end else if (m_act) begin
            if (pmn < m_mn) m_mn = pmn;
            if (pmx > m_mx) m_mx = pmx;
        end
        if (e && m_act) begin
            rng = m_mx - m_mn;
            if (rng < W'(16 << SB)) q.push_back('{W'(0), W'(65280), W'(256), cyc + 2});
            else q.push_back('{m_mn, m_mx, W'(32'd1 << 24) / rng, cyc + W + 2});
            m_act = 0;
        end
        @(posedge clk);
        @(negedge clk);
        pix_valid = 0; sof = 0; eof = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_set(input string nm, input logic [W-1:0] lo, hi, sc);
        checks += 3;
        if (low_th  !== lo) begin fails++; $display("FAIL %s_low got %0d expected %0d", nm, low_th, lo); end
        if (high_th !== hi) begin fails++; $display("FAIL %s_high got %0d expected %0d", nm, high_th, hi); end
        if (scale   !== sc) begin fails++; $display("FAIL %s_scale got %0d expected %0d", nm, scale, sc); end
    endtask

    task automatic check_idle_outputs(input string nm);
        checks += 3;
        if (pix_ready !== 1'b1) begin fails++; $display("FAIL %s_ready got %b expected 1", nm, pix_ready); end
        if (cfg_valid !== 1'b0) begin fails++; $display("FAIL %s_cfg_valid got %b expected 0", nm, cfg_valid); end
        if (busy      !== 1'b0) begin fails++; $display("FAIL %s_busy got %b expected 0", nm, busy); end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        check_set("reset", 0, 65280, 256);
        check_idle_outputs("reset");
    endtask

    task automatic test_stretch();
        beat(5000, 1280, 30000, 1, 0);
        beat(64000, 20000, 9000, 0, 0);
        beat(12345, 40000, 50000, 0, 1);
        checks += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL divide_busy got %b expected 1", busy); end
        if (pix_ready !== 1'b0) begin fails++; $display("FAIL divide_ready got %b expected 0", pix_ready); end
        drain();
        check_set("stretch", 1280, 64000, 267);
    endtask

    task automatic test_full_range();
        beat(0, 300, 65280, 1, 0);
        beat(100, 200, 300, 0, 1);
        drain();
        check_set("full", 0, 65280, 257);
    endtask

    task automatic test_flat();
        beat(25600, 25600, 25600, 1, 0);
        beat(25600, 25600, 25600, 0, 0);
        beat(25600, 25600, 25600, 0, 1);
        drain();
        check_set("flat", 0, 65280, 256);
    endtask

    task automatic test_restart();
        int n0 = n_cfg;
        beat(500, 600, 700, 1, 0);
        beat(100, 60000, 5, 0, 0);
        beat(2000, 3000, 4000, 1, 0);
        beat(8000, 2500, 30000, 0, 1);
        drain();
        check_set("restart", 2000, 30000, 599);
        checks++;
        if (n_cfg !== n0 + 1) begin fails++; $display("FAIL restart_pulses got %0d expected 1", n_cfg - n0); end
    endtask

    task automatic test_eof_in_idle();
        int n0 = n_cfg;
        beat(100, 50000, 7, 0, 1);
        repeat (40) @(negedge clk);
        checks++;
        if (n_cfg !== n0) begin fails++; $display("FAIL idle_eof_pulses got %0d expected 0", n_cfg - n0); end
    endtask

    task automatic test_reset_mid_divide();
        int n0;
        int bad = 0;
        beat(1000, 50000, 3000, 1, 1);
        R = 1000; G = 9000; B = 20000; sof = 1; eof = 1; pix_valid = 1;
        repeat (10) begin
            @(negedge clk);
            if (pix_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL divide_hold got %0d ready cycles expected 0", bad); end
        reset = 1; q.delete(); m_act = 0; n0 = n_cfg;
        @(negedge clk);
        reset = 0;
        check_set("abort", 0, 65280, 256);
        check_idle_outputs("abort");
        beat(1000, 9000, 20000, 1, 1);
        drain();
        check_set("after_abort", 1000, 20000, 883);
        checks++;
        if (n_cfg !== n0 + 1) begin fails++; $display("FAIL abort_pulses got %0d expected 1", n_cfg - n0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stretch();
        test_full_range();
        test_flat();
        test_restart();
        test_eof_in_idle();
        test_reset_mid_divide();
        checks++;
        if (q.size() != 0) begin fails++; $display("FAIL leftover got %0d expected 0", q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
